// File: rtl/main_memory_model.sv
// Block-oriented backing memory behind the cache controller: whole-block reads and
// writebacks complete after a fixed latency and are signalled by a one-cycle done_mem pulse.
module main_memory_model #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_enable,
  input  logic                          rd_wrt_mem,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W*BLOCK_WORDS-1:0] wdata,
  output logic [DATA_W*BLOCK_WORDS-1:0] rdata,
  output logic                          done_mem,
  output logic                          busy,
  output logic [1:0]                    state_dbg
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int BLK_W = ADDR_W - OFF_W;
  localparam int BW    = DATA_W * BLOCK_WORDS;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BLK_W-1:0] blk_q;
  logic             rd_q;
  logic [BW-1:0]    wdata_q;
  logic [BW-1:0]    mem [0:(1<<BLK_W)-1];

  logic [BLK_W-1:0] req_blk;
  logic             xfer;
  logic [BLK_W-1:0] xfer_blk;
  logic             xfer_rd;
  logic [BW-1:0]    xfer_wdata;

  assign req_blk   = addr[ADDR_W-1:OFF_W];
  assign state_dbg = state;

  generate
    if (OFF_W > 0) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^addr[OFF_W-1:0];
    end
  endgenerate

  // With a single-cycle latency the transfer happens on the accept edge itself,
  // so it must use the live request rather than the latched copy.
  always_comb begin
    xfer       = 1'b0;
    xfer_blk   = blk_q;
    xfer_rd    = rd_q;
    xfer_wdata = wdata_q;
    if (LATENCY == 1) begin
      xfer       = (state == IDLE) && mem_enable;
      xfer_blk   = req_blk;
      xfer_rd    = rd_wrt_mem;
      xfer_wdata = wdata;
    end else begin
      xfer = (state == ACCESS) && (cnt == CNT_W'(1));
    end
  end

  // Array contents survive reset; rst only blocks a write on the accept edge.
  always_ff @(posedge clk) begin
    if (xfer && !xfer_rd && !rst)
      mem[xfer_blk] <= xfer_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done_mem <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      cnt      <= '0;
      blk_q    <= '0;
      rd_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      if (xfer && xfer_rd)
        rdata <= mem[xfer_blk];
      case (state)
        IDLE: begin
          done_mem <= 1'b0;
          if (mem_enable) begin
            blk_q   <= req_blk;
            rd_q    <= rd_wrt_mem;
            wdata_q <= wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            busy    <= 1'b1;
            if (LATENCY == 1) begin
              state    <= DONE;
              done_mem <= 1'b1;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            done_mem <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          done_mem <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          done_mem <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_main_memory_model.sv
// Directed bench for main_memory_model: a LATENCY=4 instance and a LATENCY=1 instance
// share request buses and reset; each has its own mem_enable.
module tb_main_memory_model;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          en4, en1, rd;
  logic [AW-1:0] addr;
  logic [BW-1:0] wdata;
  logic [BW-1:0] rdata4, rdata1;
  logic          done4, done1, busy4, busy1;
  logic [1:0]    st4, st1;

  int            n_pass   = 0;
  int            n_checks = 0;
  logic [BW-1:0] exp_q[$];
  bit            done_seen;
  int            n_done;

  main_memory_model #(.DATA_W(DW), .ADDR_W(AW), .BLOCK_WORDS(4), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .mem_enable(en4), .rd_wrt_mem(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata4), .done_mem(done4), .busy(busy4), .state_dbg(st4)
  );

  main_memory_model #(.DATA_W(DW), .ADDR_W(AW), .BLOCK_WORDS(4), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_enable(en1), .rd_wrt_mem(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .done_mem(done1), .busy(busy1), .state_dbg(st1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete request on the selected instance (sel=1 -> LATENCY=1 build).
  // Latency is reported in the same cycle numbering as the accept edge: E+lat.
  task automatic access(input bit sel, input logic r, input logic [AW-1:0] a,
                        input logic [BW-1:0] wd, input int exp_lat, input string tag);
    int  k;
    bit  seen;
    bit  busy_bad;
    logic [BW-1:0] exp_rd;
    rd    = r;
    addr  = a;
    wdata = wd;
    if (sel) en1 = 1'b1; else en4 = 1'b1;
    tick;
    en4   = 1'b0;
    en1   = 1'b0;
    rd    = 1'($urandom_range(0, 1));
    addr  = AW'($urandom_range(0, 1023));
    wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    seen = 1'b0;
    busy_bad = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      if ((sel ? busy1 : busy4) !== 1'b1) busy_bad = 1'b1;
      if ((sel ? done1 : done4) === 1'b1) seen = 1'b1;
      else begin
        tick;
        k++;
      end
    end
    check({tag, "_busy_held"}, BW'(busy_bad), BW'(0));
    check({tag, "_latency"}, seen ? BW'(k + 1) : BW'(999), BW'(exp_lat));
    if (r) begin
      exp_rd = exp_q.pop_front();
      check({tag, "_rdata"}, sel ? rdata1 : rdata4, exp_rd);
    end
    tick;
    check({tag, "_done_pulse"}, BW'({sel ? done1 : done4, sel ? busy1 : busy4}), BW'(0));
  endtask

  localparam logic [BW-1:0] P1 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [BW-1:0] P3 = {32'hA5A5_0003, 32'h5A5A_0002, 32'hFFFF_0001, 32'h0000_0000};
  localparam logic [BW-1:0] PA = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
  localparam logic [BW-1:0] PB = {32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};
  localparam logic [BW-1:0] PC = {32'hCCCC_0003, 32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};
  localparam logic [BW-1:0] PD = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
  localparam logic [BW-1:0] PE = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};
  localparam logic [BW-1:0] Q1 = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
  localparam logic [BW-1:0] Q2 = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};

  initial begin
    rst = 1'b1; en4 = 1'b0; en1 = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick;
    check("rst_done4",  BW'(done4),  BW'(0));
    check("rst_busy4",  BW'(busy4),  BW'(0));
    check("rst_rdata4", rdata4,      BW'(0));
    check("rst_state4", BW'(st4),    BW'(0));
    check("rst_done1",  BW'(done1),  BW'(0));
    check("rst_rdata1", rdata1,      BW'(0));
    rst = 1'b0;
    tick;

    // write then read with ignored low address bits
    access(1'b0, 1'b0, 10'h010, P1, 4, "t1_wr");
    check("t1_rdata_hold", rdata4, BW'(0));
    exp_q.push_back(P1);
    access(1'b0, 1'b1, 10'h013, '0, 4, "t2_rd");

    // mem_enable held high across a whole access plus the following idle cycle
    rd = 1'b0; addr = 10'h040; wdata = P3; en4 = 1'b1;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i < 5 && done4 === 1'b1) n_done++;
      if (i == 4) check("t3_idle_gap_busy", BW'(busy4), BW'(0));
      if (i == 5) check("t3_reaccept_busy", BW'(busy4), BW'(1));
    end
    en4 = 1'b0;
    check("t3_done_count", BW'(n_done), BW'(1));
    done_seen = 1'b0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      tick;
      if (done4 === 1'b1) done_seen = 1'b1;
    end
    check("t3_second_done", BW'(done_seen), BW'(1));
    tick;
    exp_q.push_back(P3);
    access(1'b0, 1'b1, 10'h041, '0, 4, "t3_rd");

    // reset in the middle of a write aborts it
    access(1'b0, 1'b0, 10'h020, PA, 4, "t4_wr_a");
    exp_q.push_back(PA);
    access(1'b0, 1'b1, 10'h020, '0, 4, "t4_rd_a");
    rd = 1'b0; addr = 10'h020; wdata = PB; en4 = 1'b1;
    tick;
    en4 = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #2;
    check("t4_async_busy",  BW'(busy4), BW'(0));
    check("t4_async_rdata", rdata4,     BW'(0));
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done4 === 1'b1) done_seen = 1'b1;
    end
    check("t4_no_done", BW'(done_seen), BW'(0));
    exp_q.push_back(PA);
    access(1'b0, 1'b1, 10'h020, '0, 4, "t4_rd_after");

    // top block and its neighbours
    access(1'b0, 1'b0, 10'h000, PE, 4, "t6_wr_000");
    access(1'b0, 1'b0, 10'h3F8, PD, 4, "t6_wr_3f8");
    access(1'b0, 1'b0, 10'h3FC, PC, 4, "t6_wr_3fc");
    exp_q.push_back(PC);
    access(1'b0, 1'b1, 10'h3FF, '0, 4, "t6_rd_3ff");
    exp_q.push_back(PD);
    access(1'b0, 1'b1, 10'h3F8, '0, 4, "t6_rd_3f8");
    exp_q.push_back(PE);
    access(1'b0, 1'b1, 10'h000, '0, 4, "t6_rd_000");
    exp_q.push_back(P1);
    access(1'b0, 1'b1, 10'h010, '0, 4, "t6_rd_010");

    // LATENCY=1 build, back-to-back reads
    access(1'b1, 1'b0, 10'h3FC, Q1, 1, "t5_wr_3fc");
    access(1'b1, 1'b0, 10'h000, Q2, 1, "t5_wr_000");
    exp_q.push_back(Q1);
    access(1'b1, 1'b1, 10'h3FC, '0, 1, "t5_rd_3fc");
    exp_q.push_back(Q2);
    access(1'b1, 1'b1, 10'h000, '0, 1, "t5_rd_000");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
